// File: rtl/divmmc_spi_if.sv
// Z80-side and pin-side signal bundle for the DivMMC SPI master.
// Build option DIVMMC_SPI_RDTRIG_EN adds the read-triggered exchange strobe rd.
interface divmmc_spi_if;
  logic       ce;
  logic       csWr;
  logic       csD;
  logic       wr;
  logic [7:0] d;
  logic [7:0] q;
  logic       busy;
  logic       cs;
  logic       ck;
  logic       mosi;
  logic       miso;
`ifdef DIVMMC_SPI_RDTRIG_EN
  logic       rd;
`endif

  // master: port decode plus the card pins feeding back into the core
  modport master (
`ifdef DIVMMC_SPI_RDTRIG_EN
    output rd,
`endif
    output ce, csWr, csD, wr, d, miso,
    input  q, busy, cs, ck, mosi
  );

  modport slave (
`ifdef DIVMMC_SPI_RDTRIG_EN
    input  rd,
`endif
    input  ce, csWr, csD, wr, d, miso,
    output q, busy, cs, ck, mosi
  );
endinterface

// File: rtl/divmmc_spi.sv
// SPI mode-0 master for the DivMMC SD port: each data write runs one 8-bit exchange.
// Build option DIVMMC_SPI_RDTRIG_EN lets a data-port read start an 8'hFF read-ahead exchange.
module divmmc_spi #(
  parameter bit MOSI_IDLE = 1'b1,
  parameter bit CS_RESET  = 1'b1
) (
  input logic        clock,
  input logic        reset,
  divmmc_spi_if.slave bus
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] txs;
  logic [7:0] rxs;
  logic [7:0] q_r;
  logic       busy_r;
  logic       cs_r;
  logic       ck_r;
  logic       mosi_r;

  logic       start;
  logic [7:0] tx_byte;

`ifdef DIVMMC_SPI_RDTRIG_EN
  // wr has priority over rd; a read-triggered exchange clocks out all ones
  assign start   = bus.wr | bus.rd;
  assign tx_byte = bus.wr ? bus.d : 8'hFF;
`else
  assign start   = bus.wr;
  assign tx_byte = bus.d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      txs    <= 8'd0;
      rxs    <= 8'd0;
      q_r    <= 8'hFF;
      busy_r <= 1'b0;
      cs_r   <= CS_RESET;
      ck_r   <= 1'b0;
      mosi_r <= MOSI_IDLE;
    end else begin
      // chip select is independent of the exchange engine
      if (bus.csWr)
        cs_r <= bus.csD;

      case (state)
        IDLE: begin
          if (start) begin
            txs    <= tx_byte;
            mosi_r <= tx_byte[7];
            cnt    <= 4'd0;
            busy_r <= 1'b1;
            state  <= XFER;
          end
        end

        XFER: begin
          if (bus.ce) begin
            if (!cnt[0]) begin
              ck_r <= 1'b1;
              rxs  <= {rxs[6:0], bus.miso};
              cnt  <= cnt + 4'd1;
            end else if (cnt == 4'd15) begin
              // rxs already holds all eight rising-edge samples here
              ck_r   <= 1'b0;
              mosi_r <= MOSI_IDLE;
              q_r    <= rxs;
              busy_r <= 1'b0;
              cnt    <= 4'd0;
              state  <= IDLE;
            end else begin
              ck_r   <= 1'b0;
              txs    <= {txs[6:0], 1'b0};
              mosi_r <= txs[6];
              cnt    <= cnt + 4'd1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q    = q_r;
  assign bus.busy = busy_r;
  assign bus.cs   = cs_r;
  assign bus.ck   = ck_r;
  assign bus.mosi = mosi_r;

endmodule
